// File: rtl/hazard_issue_ctrl.sv
// In-order issue control: RAW scoreboard hazard bubbles, two-bubble branch
// shadow and fetch-pc sequencing. The downstream stall_in freezes everything.
module hic_sb_cnt #(
    parameter int RAW_GAP = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic busy
);
    localparam logic [1:0] GAP = RAW_GAP[1:0];

    logic [1:0] cnt;

    // A reload by a new writer takes priority over the per-cycle countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 2'd0;
        else if (en) begin
            if (load)
                cnt <= GAP;
            else if (cnt != 2'd0)
                cnt <= cnt - 2'd1;
        end
    end

    assign busy = (cnt != 2'd0);
endmodule

module hazard_issue_ctrl #(
    parameter int         RAW_GAP  = 3,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_in,
    input  logic        stall_in,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  pc,
    output logic [15:0] inst_out,
    output logic        inst_valid
);
    localparam int NUM_REGS = 8;

    typedef enum logic [1:0] {RUN, BR1, BR2} state_t;

    typedef struct packed {
        logic       has_dest;
        logic [2:0] dest;
        logic       use_a;
        logic [2:0] src_a;
        logic       use_b;
        logic [2:0] src_b;
        logic       is_br;
    } dec_t;

    state_t                state, state_nxt;
    dec_t                  dec;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   load;
    logic                  hazard, issue;
    logic [7:0]            pc_nxt;
    logic [15:0]           out_nxt;
    logic                  vld_nxt;
    logic                  unused_bits;

    assign unused_bits = ^inst_in[12:9];

    always_comb begin
        dec = '0;
        if (inst_in != 16'h0000) begin
            unique case (inst_in[15:13])
                3'b000: begin
                    dec.has_dest = 1'b1;
                    dec.dest     = inst_in[8:6];
                    dec.use_a    = 1'b1;
                    dec.src_a    = inst_in[5:3];
                    dec.use_b    = 1'b1;
                    dec.src_b    = inst_in[2:0];
                end
                3'b001, 3'b010: begin
                    dec.has_dest = 1'b1;
                    dec.dest     = inst_in[2:0];
                end
                3'b011: begin
                    dec.use_a = 1'b1;
                    dec.src_a = inst_in[2:0];
                end
                3'b100:  dec.is_br = 1'b1;
                default: dec = '0;
            endcase
        end
    end

    // Only RUN looks at inst_in; in the branch shadow pc still points at the branch.
    assign hazard = (state == RUN) &&
                    ((dec.use_a && busy[dec.src_a]) || (dec.use_b && busy[dec.src_b]));
    assign issue  = (state == RUN) && !hazard;

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_sb
            assign load[r] = issue && dec.has_dest && (dec.dest == 3'(r));
            hic_sb_cnt #(.RAW_GAP(RAW_GAP)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .en   (!stall_in),
                .load (load[r]),
                .busy (busy[r])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        out_nxt   = 16'h0000;
        vld_nxt   = 1'b0;
        unique case (state)
            RUN: begin
                if (!hazard) begin
                    out_nxt = inst_in;
                    vld_nxt = 1'b1;
                    if (dec.is_br)
                        state_nxt = BR1;
                    else
                        pc_nxt = pc + 8'd1;
                end
            end
            BR1: state_nxt = BR2;
            BR2: begin
                state_nxt = RUN;
                pc_nxt    = branch_taken ? branch_target : pc + 8'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            inst_out   <= 16'h0000;
            inst_valid <= 1'b0;
        end else if (!stall_in) begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_out   <= out_nxt;
            inst_valid <= vld_nxt;
        end
    end
endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Randomized + directed bench for hazard_issue_ctrl; a slot-based reference
// model predicts every cycle's outputs into a queue that a monitor drains.
module tb_hazard_issue_ctrl;
    localparam int         RAW_GAP  = 3;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_in;
    logic        stall_in = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  pc;
    logic [15:0] inst_out;
    logic        inst_valid;

    logic [15:0] mem [256];
    int total = 0;
    int bad = 0;

    hazard_issue_ctrl #(.RAW_GAP(RAW_GAP), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .stall_in(stall_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;
    assign inst_in = mem[pc];

    // Reference model: a register written in issue slot t is readable from
    // slot t+RAW_GAP+1; a branch is followed by two bubble slots.
    logic [7:0]  m_pc  = RESET_PC;
    logic [15:0] m_out = 16'h0000;
    logic        m_vld = 1'b0;
    int          m_bub = 0;
    int          m_slot = 0;
    int          ready [8] = '{default: 0};
    logic [24:0] expq [$];

    task automatic decode(input logic [15:0] ins, output int dst, output int srcs[$], output bit br);
        dst = -1; srcs = {}; br = 0;
        if (ins != 16'h0000) begin
            case (ins[15:13])
                3'd0: begin dst = int'(ins[8:6]); srcs = {int'(ins[5:3]), int'(ins[2:0])}; end
                3'd1, 3'd2: dst = int'(ins[2:0]);
                3'd3: srcs = {int'(ins[2:0])};
                3'd4: br = 1;
                default: ;
            endcase
        end
    endtask

    task automatic model_step();
        int dst; int srcs[$]; bit br; bit hz;
        if (m_bub == 2) begin
            m_out = 16'h0000; m_vld = 1'b0; m_bub = 1;
        end else if (m_bub == 1) begin
            m_out = 16'h0000; m_vld = 1'b0; m_bub = 0;
            m_pc = branch_taken ? branch_target : m_pc + 8'd1;
        end else begin
            decode(mem[m_pc], dst, srcs, br);
            hz = 0;
            foreach (srcs[i]) if (m_slot < ready[srcs[i]]) hz = 1;
            if (hz) begin
                m_out = 16'h0000; m_vld = 1'b0;
            end else begin
                m_out = mem[m_pc]; m_vld = 1'b1;
                if (br) m_bub = 2;
                else m_pc = m_pc + 8'd1;
                if (dst >= 0) ready[dst] = m_slot + RAW_GAP + 1;
            end
        end
        m_slot++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RESET_PC; m_out = 16'h0000; m_vld = 1'b0;
            m_bub = 0; m_slot = 0;
            for (int i = 0; i < 8; i++) ready[i] = 0;
        end else begin
            if (!stall_in) model_step();
            expq.push_back({m_pc, m_out, m_vld});
        end
    end

    always @(posedge clk) begin
        logic [24:0] e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            total++;
            if ({pc, inst_out, inst_valid} !== e) begin
                bad++;
                $display("FAIL sb t=%0t pc=%h out=%h vld=%b expected pc=%h out=%h vld=%b",
                         $time, pc, inst_out, inst_valid, e[24:17], e[16:1], e[0]);
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h2007;
    endtask

    // Async pulse placed between edges; reset values must appear at once.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_pc", 16'(pc), 16'(RESET_PC));
        check("rst_out", inst_out, 16'h0000);
        check("rst_vld", 16'(inst_valid), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq(input string nm, input logic [15:0] outs[$], input logic vlds[$]);
        foreach (outs[k]) begin
            @(negedge clk);
            check({nm, "_out"}, inst_out, outs[k]);
            check({nm, "_vld"}, 16'(inst_valid), 16'(vlds[k]));
        end
    endtask

    initial begin
        logic [15:0] o[$];
        logic        v[$];
        rst = 1'b1;
        clear_mem();
        mem[0] = 16'h005A; mem[1] = 16'h010A;
        #1;
        check("init_pc", 16'(pc), 16'(RESET_PC));
        check("init_vld", 16'(inst_valid), 16'h0000);
        @(negedge clk) rst = 1'b0;

        // RAW chain: three bubbles between writer and dependent reader
        o = {16'h005A, 16'h0000, 16'h0000, 16'h0000, 16'h010A};
        v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_seq("raw", o, v);

        // store depends on r1 but a load slipped in between: two bubbles
        clear_mem();
        mem[0] = 16'h005A; mem[1] = 16'h2002; mem[2] = 16'h6001;
        pulse_reset();
        o = {16'h005A, 16'h2002, 16'h0000, 16'h0000, 16'h6001};
        v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run_seq("st", o, v);

        // stall during hazard bubbles freezes outputs
        clear_mem();
        mem[0] = 16'h005A; mem[1] = 16'h010A;
        pulse_reset();
        @(negedge clk); @(negedge clk);
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_out", inst_out, 16'h0000);
            check("stall_pc", 16'(pc), 16'h0001);
        end
        stall_in = 1'b0;
        o = {16'h0000, 16'h0000, 16'h010A};
        v = {1'b0, 1'b0, 1'b1};
        run_seq("stall_rel", o, v);

        // branch at pc 5, taken then not taken
        for (int tk = 1; tk >= 0; tk--) begin
            clear_mem();
            for (int i = 0; i < 5; i++) mem[i] = 16'h2001 + 16'(i);
            mem[5] = 16'h8000;
            branch_taken = tk[0]; branch_target = 8'h40;
            pulse_reset();
            repeat (6) @(negedge clk);
            check("br_issue", inst_out, 16'h8000);
            check("br_pc", 16'(pc), 16'h0005);
            o = {16'h0000, 16'h0000};
            v = {1'b0, 1'b0};
            run_seq("br_bub", o, v);
            check("br_dest", 16'(pc), tk ? 16'h0040 : 16'h0006);
        end

        // pc wrap at 8'hFF
        clear_mem();
        mem[0] = 16'h8000; mem[255] = 16'h2003;
        branch_taken = 1'b1; branch_target = 8'hFF;
        pulse_reset();
        repeat (4) @(negedge clk);
        check("wrap_out", inst_out, 16'h2003);
        check("wrap_pc", 16'(pc), 16'h0000);

        // reset while in BR1, then clean restart
        clear_mem();
        mem[0] = 16'h8000;
        pulse_reset();
        @(negedge clk);
        check("br1_pre", inst_out, 16'h8000);
        mem[0] = 16'h2003;
        pulse_reset();
        @(negedge clk);
        check("br1_rst_out", inst_out, 16'h2003);
        check("br1_rst_vld", 16'(inst_valid), 16'h0001);
        check("br1_rst_pc", 16'(pc), 16'h0001);

        // random programs with small register set to force hazards
        for (int i = 0; i < 256; i++)
            mem[i] = {3'($urandom_range(0, 7)), 4'($urandom), 3'($urandom_range(0, 3)),
                      3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            stall_in      = ($urandom_range(0, 5) == 0);
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
            if (c % 300 == 299) begin
                stall_in = 1'b0;
                pulse_reset();
            end
        end
        stall_in = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
